tick_divider_multi: RTL and testbench

//   Multi-channel programmable tick divider. Counts qualifying input ticks (e.g. the
//   1 ms tick) per channel and emits derived timebases (20 ms scan, debounce, blink).

---
 rtl/tick_divider_multi.sv | 81 ++++++++
 tb/tb_tick_divider_multi.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tick_divider_multi.sv
// Multi-channel programmable tick divider: each channel counts qualifying ticks and
// emits a terminal-count pulse, a square wave (mode 01) or a one-shot done flag (mode 10).
module tick_divider_multi #(
  parameter int CH          = 4,
  parameter int CNT_W       = 16,
  parameter int DEFAULT_DIV = 20,
  localparam int SEL_W      = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick_in,
  input  logic             sync_clr,
  input  logic [CH-1:0]    ch_en,
  input  logic             cfg_we,
  input  logic [SEL_W-1:0] cfg_sel,
  input  logic [CNT_W-1:0] cfg_div,
  input  logic [1:0]       cfg_mode,
  output logic [CH-1:0]    pulse_out,
  output logic [CH-1:0]    level_out,
  output logic [CH-1:0]    done
);

  localparam logic [1:0] MODE_SQUARE  = 2'b01;
  localparam logic [1:0] MODE_ONESHOT = 2'b10;

  for (genvar i = 0; i < CH; i++) begin : g_ch
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] div;
    logic [1:0]       mode;
    logic             pulse;
    logic             level;
    logic             fin;
    logic             sel_hit;
    logic             step;

    // Out-of-range selects never match, so such writes fall through harmlessly.
    assign sel_hit = cfg_we && (32'(cfg_sel) == i);
    // A finished one-shot stops counting and stays parked at zero.
    assign step    = tick_in && ch_en[i] && !(mode == MODE_ONESHOT && fin);

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        cnt   <= '0;
        div   <= CNT_W'(DEFAULT_DIV);
        mode  <= 2'b00;
        pulse <= 1'b0;
        level <= 1'b0;
        fin   <= 1'b0;
      end else if (sync_clr) begin
        cnt   <= '0;
        pulse <= 1'b0;
        level <= 1'b0;
        fin   <= 1'b0;
      end else if (sel_hit) begin
        div   <= cfg_div;
        mode  <= cfg_mode;
        cnt   <= '0;
        pulse <= 1'b0;
        level <= 1'b0;
        fin   <= 1'b0;
      end else begin
        pulse <= 1'b0;
        if (step) begin
          if (cnt == div) begin
            cnt   <= '0;
            pulse <= 1'b1;
            if (mode == MODE_SQUARE)  level <= ~level;
            if (mode == MODE_ONESHOT) fin   <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
      end
    end

    assign pulse_out[i] = pulse;
    assign level_out[i] = level;
    assign done[i]      = fin;
  end

endmodule

// File: tb/tb_tick_divider_multi.sv
// Bench for tick_divider_multi: directed scenarios plus random traffic against a
// tick-count reference model; a second 1-channel 4-bit instance covers full-scale.
module tb_tick_divider_multi;
  localparam int CH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        tick_in = 1'b0, sync_clr = 1'b0, cfg_we = 1'b0;
  logic [CH-1:0] ch_en = '0;
  logic [1:0]  cfg_sel = '0;
  logic [15:0] cfg_div = '0;
  logic [1:0]  cfg_mode = '0;
  logic [CH-1:0] pulse_out, level_out, done;

  logic       s_tick = 1'b0, s_clr = 1'b0, s_we = 1'b0;
  logic [0:0] s_en = 1'b1, s_sel = 1'b0;
  logic [3:0] s_div = '0;
  logic [1:0] s_mode = '0;
  logic [0:0] s_pulse, s_level, s_done;

  int checks = 0;
  int failures = 0;

  // Reference model: qualifying ticks since the last restart of each channel.
  longint m_ticks [CH];
  int     m_div   [CH];
  int     m_mode  [CH];
  bit     m_pulse [CH];

  always #5 clk = ~clk;

  tick_divider_multi #(.CH(CH), .CNT_W(16), .DEFAULT_DIV(20)) dut (
    .clk(clk), .reset(reset), .tick_in(tick_in), .sync_clr(sync_clr), .ch_en(ch_en),
    .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_div(cfg_div), .cfg_mode(cfg_mode),
    .pulse_out(pulse_out), .level_out(level_out), .done(done));

  tick_divider_multi #(.CH(1), .CNT_W(4), .DEFAULT_DIV(20)) dut_small (
    .clk(clk), .reset(reset), .tick_in(s_tick), .sync_clr(s_clr), .ch_en(s_en),
    .cfg_we(s_we), .cfg_sel(s_sel), .cfg_div(s_div), .cfg_mode(s_mode),
    .pulse_out(s_pulse), .level_out(s_level), .done(s_done));

  function automatic bit m_done(int i);
    return (m_mode[i] == 2) && (m_ticks[i] >= longint'(m_div[i]) + 1);
  endfunction

  function automatic bit m_level(int i);
    longint per = longint'(m_div[i]) + 1;
    return (m_mode[i] == 1) && (((m_ticks[i] / per) % 2) == 1);
  endfunction

  function automatic logic [3*CH-1:0] expect_vec();
    logic [CH-1:0] p, l, d;
    for (int i = 0; i < CH; i++) begin
      p[i] = m_pulse[i];
      l[i] = m_level(i);
      d[i] = m_done(i);
    end
    return {p, l, d};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < CH; i++) begin
      m_ticks[i] = 0; m_div[i] = 20; m_mode[i] = 0; m_pulse[i] = 0;
    end
  endtask

  task automatic model_clk();
    for (int i = 0; i < CH; i++) begin
      m_pulse[i] = 0;
      if (sync_clr) m_ticks[i] = 0;
      else if (cfg_we && int'(cfg_sel) == i) begin
        m_div[i] = int'(cfg_div); m_mode[i] = int'(cfg_mode); m_ticks[i] = 0;
      end else if (tick_in && ch_en[i] && !m_done(i)) begin
        m_ticks[i]++;
        if (m_ticks[i] % (longint'(m_div[i]) + 1) == 0) m_pulse[i] = 1;
      end
    end
  endtask

  task automatic tick_clk();
    @(posedge clk);
    if (reset) model_clk();
    #1;
  endtask

  task automatic write_cfg(int sel, int dv, int md, bit with_tick);
    cfg_we = 1'b1; cfg_sel = 2'(sel); cfg_div = 16'(dv); cfg_mode = 2'(md);
    tick_in = with_tick;
    tick_clk();
    cfg_we = 1'b0; tick_in = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #3 reset = 1'b1;
    #1;
    checks++;
    if ({pulse_out, level_out, done} !== 12'h000) begin
      failures++; $display("FAIL reset_outputs got=%h exp=000", {pulse_out, level_out, done});
    end
    checks++;
    if ({s_pulse, s_level, s_done} !== 3'b000) begin
      failures++; $display("FAIL reset_small got=%b exp=000", {s_pulse, s_level, s_done});
    end
  endtask

  task automatic test_default();
    int np = 0;
    ch_en = '1;
    for (int c = 0; c < 21 * 4 * 2; c++) begin
      tick_in = (c % 4 == 3);
      tick_clk();
      tick_in = 1'b0;
      checks++;
      if ({pulse_out, level_out, done} !== expect_vec()) begin
        failures++;
        $display("FAIL default_cycle%0d got=%h exp=%h", c, {pulse_out, level_out, done}, expect_vec());
      end
      if (pulse_out[0]) np++;
    end
    checks++;
    if (np != 2) begin failures++; $display("FAIL default_pulse_count got=%0d exp=2", np); end
  endtask

  task automatic test_square();
    int toggles = 0, np = 0;
    logic prev;
    write_cfg(1, 3, 1, 1'b0);
    prev = level_out[1];
    for (int c = 0; c < 32; c++) begin
      tick_in = (c % 2 == 0);
      tick_clk();
      tick_in = 1'b0;
      checks++;
      if ({pulse_out, level_out, done} !== expect_vec()) begin
        failures++;
        $display("FAIL square_cycle%0d got=%h exp=%h", c, {pulse_out, level_out, done}, expect_vec());
      end
      if (level_out[1] != prev) toggles++;
      if (pulse_out[1]) np++;
      prev = level_out[1];
    end
    checks++;
    if (toggles != 4 || np != 4) begin
      failures++; $display("FAIL square_toggles got=%0d/%0d exp=4/4", toggles, np);
    end
  endtask

  task automatic test_oneshot();
    int np = 0, at = -1;
    write_cfg(2, 5, 2, 1'b0);
    for (int c = 0; c < 18; c++) begin
      tick_in = 1'b1;
      tick_clk();
      checks++;
      if ({pulse_out, level_out, done} !== expect_vec()) begin
        failures++;
        $display("FAIL oneshot_cycle%0d got=%h exp=%h", c, {pulse_out, level_out, done}, expect_vec());
      end
      if (pulse_out[2]) begin np++; at = c; end
    end
    tick_in = 1'b0;
    checks++;
    if (np != 1 || at != 5 || done[2] !== 1'b1) begin
      failures++; $display("FAIL oneshot_single got=n%0d@%0d d%b exp=n1@5 d1", np, at, done[2]);
    end
    write_cfg(2, 5, 2, 1'b0);
    checks++;
    if (done[2] !== 1'b0) begin failures++; $display("FAIL oneshot_rearm got=%b exp=0", done[2]); end
    np = 0;
    for (int c = 0; c < 6; c++) begin
      tick_in = 1'b1;
      tick_clk();
      if (pulse_out[2]) np++;
    end
    tick_in = 1'b0;
    checks++;
    if (np != 1 || done[2] !== 1'b1) begin
      failures++; $display("FAIL oneshot_restart got=n%0d d%b exp=n1 d1", np, done[2]);
    end
  endtask

  task automatic test_div0();
    int np = 0, first = -1;
    write_cfg(3, 0, 0, 1'b0);
    for (int c = 0; c < 5; c++) begin
      tick_in = 1'b1;
      tick_clk();
      if (pulse_out[3]) np++;
      checks++;
      if ({pulse_out, level_out, done} !== expect_vec()) begin
        failures++;
        $display("FAIL div0_cycle%0d got=%h exp=%h", c, {pulse_out, level_out, done}, expect_vec());
      end
    end
    checks++;
    if (np != 5) begin failures++; $display("FAIL div0_every_tick got=%0d exp=5", np); end
    // Tick coincident with the write must be dropped: period 3 restarts from zero.
    write_cfg(3, 2, 0, 1'b1);
    for (int c = 0; c < 3; c++) begin
      tick_in = 1'b1;
      tick_clk();
      if (pulse_out[3] && first < 0) first = c;
    end
    tick_in = 1'b0;
    checks++;
    if (first != 2) begin failures++; $display("FAIL write_drops_tick got=%0d exp=2", first); end
  endtask

  task automatic test_hold();
    int np = 0, at = -1;
    sync_clr = 1'b1; tick_clk(); sync_clr = 1'b0;
    ch_en = '1;
    for (int c = 0; c < 10; c++) begin tick_in = 1'b1; tick_clk(); end
    ch_en[0] = 1'b0;
    for (int c = 0; c < 50; c++) begin
      tick_in = 1'b1;
      tick_clk();
      if (pulse_out[0]) np++;
    end
    ch_en[0] = 1'b1;
    for (int c = 0; c < 11; c++) begin
      tick_in = 1'b1;
      tick_clk();
      if (pulse_out[0]) begin np++; at = c; end
      checks++;
      if ({pulse_out, level_out, done} !== expect_vec()) begin
        failures++;
        $display("FAIL hold_cycle%0d got=%h exp=%h", c, {pulse_out, level_out, done}, expect_vec());
      end
    end
    tick_in = 1'b0;
    checks++;
    if (np != 1 || at != 10) begin
      failures++; $display("FAIL hold_resume got=n%0d@%0d exp=n1@10", np, at);
    end
    sync_clr = 1'b1; tick_clk(); sync_clr = 1'b0;
    checks++;
    if ({pulse_out, level_out, done} !== 12'h000) begin
      failures++; $display("FAIL sync_clr got=%h exp=000", {pulse_out, level_out, done});
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 3000; c++) begin
      tick_in  = 1'($urandom_range(0, 1));
      ch_en    = 4'($urandom_range(0, 15));
      cfg_we   = ($urandom_range(0, 15) == 0);
      cfg_sel  = 2'($urandom_range(0, 3));
      cfg_div  = 16'($urandom_range(0, 6));
      cfg_mode = 2'($urandom_range(0, 3));
      sync_clr = ($urandom_range(0, 63) == 0);
      tick_clk();
      checks++;
      if ({pulse_out, level_out, done} !== expect_vec()) begin
        failures++;
        $display("FAIL random_cycle%0d got=%h exp=%h", c, {pulse_out, level_out, done}, expect_vec());
      end
    end
    tick_in = 1'b0; cfg_we = 1'b0; sync_clr = 1'b0; ch_en = '1;
  endtask

  task automatic test_async_reset();
    int np = 0, at = -1;
    write_cfg(1, 0, 1, 1'b0);
    tick_in = 1'b1; tick_clk(); tick_in = 1'b0;
    checks++;
    if (level_out[1] !== 1'b1 || pulse_out[1] !== 1'b1) begin
      failures++; $display("FAIL async_setup got=%b%b exp=11", level_out[1], pulse_out[1]);
    end
    #1 reset = 1'b0;
    model_reset();
    #1;
    checks++;
    if ({pulse_out, level_out, done} !== 12'h000) begin
      failures++; $display("FAIL async_reset got=%h exp=000", {pulse_out, level_out, done});
    end
    #1 reset = 1'b1;
    for (int c = 0; c < 21; c++) begin
      tick_in = 1'b1;
      tick_clk();
      if (pulse_out[0]) begin np++; at = c; end
      checks++;
      if ({pulse_out, level_out, done} !== expect_vec()) begin
        failures++;
        $display("FAIL post_reset_cycle%0d got=%h exp=%h", c, {pulse_out, level_out, done}, expect_vec());
      end
    end
    tick_in = 1'b0;
    checks++;
    if (np != 1 || at != 20) begin
      failures++; $display("FAIL post_reset_div got=n%0d@%0d exp=n1@20", np, at);
    end
  endtask

  task automatic test_full_scale();
    int np = 0;
    logic ep, el;
    s_we = 1'b1; s_sel = 1'b0; s_div = 4'd15; s_mode = 2'b01;
    tick_clk();
    s_sel = 1'b1; s_div = 4'd0; s_mode = 2'b00;
    tick_clk();
    s_we = 1'b0;
    for (int k = 0; k < 32; k++) begin
      s_tick = 1'b1;
      tick_clk();
      ep = (k % 16 == 15);
      el = (((k + 1) / 16) % 2 == 1);
      if (s_pulse[0]) np++;
      checks++;
      if ({s_pulse, s_level, s_done} !== {ep, el, 1'b0}) begin
        failures++;
        $display("FAIL full_scale_tick%0d got=%b exp=%b", k, {s_pulse, s_level, s_done}, {ep, el, 1'b0});
      end
    end
    s_tick = 1'b0;
    checks++;
    if (np != 2) begin failures++; $display("FAIL full_scale_pulses got=%0d exp=2", np); end
  endtask

  initial begin
    test_reset();
    test_default();
    test_square();
    test_oneshot();
    test_div0();
    test_hold();
    test_random();
    test_async_reset();
    test_full_scale();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
